// File: rtl/denormalize.sv
`timescale 1ns/1ps
// denormalize: undoes a left normalization by shifting right one bit per
// clock, with optional round-half-up on the last bit shifted out.
module denormalize #(
    parameter int W        = 10,
    parameter int SW       = 5,
    parameter int ROUND_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  val_in,
    input  logic [SW-1:0] square_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  val_out,
    output logic          out_err,
    output logic          out_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          rbit_q, rbit_d;
    logic [W-1:0]  val_q, val_d;
    logic          err_q, err_d;
    logic          zero_q, zero_d;

    logic          sq_big;
    logic          sq_nil;
    logic          last;
    logic          rnd;
    logic [W-1:0]  last_val;

    assign sq_big = (32'(square_in) >= W);
    assign sq_nil = (square_in == '0);
    assign last   = (cnt_q == SW'(1));
    assign rnd    = (ROUND_EN != 0) && data_q[0];
    assign last_val = (data_q >> 1) + {{(W-1){1'b0}}, rnd};

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            rbit_q  <= 1'b0;
            val_q   <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rbit_q  <= rbit_d;
            val_q   <= val_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state: shifts complete on the edge where the count reaches one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (sq_big || sq_nil) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift in SHIFT, publish result on last edge.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        rbit_d = rbit_q;
        val_d  = val_q;
        err_d  = err_q;
        zero_d = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (sq_big) begin
                        val_d  = '0;
                        err_d  = 1'b1;
                        zero_d = 1'b1;
                    end else if (sq_nil) begin
                        val_d  = val_in;
                        err_d  = 1'b0;
                        zero_d = (val_in == '0);
                    end else begin
                        data_d = val_in;
                        cnt_d  = square_in;
                        rbit_d = 1'b0;
                    end
                end
            end
            S_SHIFT: begin
                data_d = data_q >> 1;
                rbit_d = data_q[0];
                cnt_d  = cnt_q - SW'(1);
                if (last) begin
                    val_d  = last_val;
                    err_d  = 1'b0;
                    zero_d = (last_val == '0);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        val_out   = val_q;
        out_err   = err_q;
        out_zero  = zero_q;
    end

endmodule

// File: tb/tb_denormalize.sv
`timescale 1ns/1ps
// Bench for denormalize: vector table, directed corner sequences and
// randomized operations against an arithmetic reference model.
module tb_denormalize;

    localparam int W  = 10;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  val_in = '0;
    logic [SW-1:0] square_in = '0;
    logic          in_ready, out_valid, out_err, out_zero;
    logic [W-1:0]  val_out;
    logic          t_in_ready, t_out_valid, t_out_err, t_out_zero;
    logic [W-1:0]  t_val_out;

    denormalize #(.W(W), .SW(SW), .ROUND_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .val_in(val_in), .square_in(square_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .val_out(val_out), .out_err(out_err), .out_zero(out_zero)
    );

    denormalize #(.W(W), .SW(SW), .ROUND_EN(0)) u_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .val_in(val_in), .square_in(square_in),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .val_out(t_val_out), .out_err(t_out_err), .out_zero(t_out_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int v;
        int s;
        int ev;
        int ee;
        int ez;
    } vec_t;

    vec_t tbl[12];

    // Reference: result = round(v / 2^s) with ties up, or floor when truncating.
    function automatic int model(input int v, input int s, input bit rnd);
        if (s >= W) return 0;
        if (s == 0) return v;
        if (rnd) return (v + (1 << (s - 1))) >> s;
        return v >> s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic run(input int v, input int s, input int hold,
                       input int ev, input int ee, input int ez,
                       output int acc);
        int lat;
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        val_in    = W'(v);
        square_in = SW'(s);
        @(posedge clk); #1;
        acc = cyc;
        in_valid  = 1'b0;
        val_in    = W'($urandom);
        square_in = SW'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, (s == 0 || s >= W) ? 1 : s + 1);
        chk("val_out", int'(val_out), ev);
        chk("out_err", int'(out_err), ee);
        chk("out_zero", int'(out_zero), ez);
        chk("trunc_val", int'(t_val_out), model(v, s, 1'b0));
        chk("trunc_valid", int'(t_out_valid), 1);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            val_in    = W'($urandom);
            square_in = 5'd1;
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_val", int'(val_out), ev);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after", int'(in_ready), 1);
        chk("valid_after", int'(out_valid), 0);
    endtask

    initial begin
        int acc;
        int prev_acc;
        int prev_s;
        int seen;
        int v;
        int s;
        int ev;

        tbl[0]  = '{704, 3, 88, 0, 0};
        tbl[1]  = '{771, 2, 193, 0, 0};
        tbl[2]  = '{600, 0, 600, 0, 0};
        tbl[3]  = '{512, 12, 0, 1, 1};
        tbl[4]  = '{1023, 9, 2, 0, 0};
        tbl[5]  = '{0, 5, 0, 0, 1};
        tbl[6]  = '{1, 1, 1, 0, 0};
        tbl[7]  = '{1023, 1, 512, 0, 0};
        tbl[8]  = '{700, 10, 0, 1, 1};
        tbl[9]  = '{640, 31, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 1};
        tbl[11] = '{512, 9, 1, 0, 0};

        #12;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_val", int'(val_out), 0);
        chk("rst_err", int'(out_err), 0);
        chk("rst_zero", int'(out_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        prev_acc = 0;
        prev_s = 0;
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].v, tbl[i].s, 0, tbl[i].ev, tbl[i].ee, tbl[i].ez, acc);
            if (i > 0)
                chk("interval", acc - prev_acc, (prev_s >= W ? 0 : prev_s) + 2);
            prev_acc = acc;
            prev_s = tbl[i].s;
        end

        run(640, 1, 5, 320, 0, 0, acc);

        in_valid  = 1'b1;
        val_in    = 10'd700;
        square_in = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_val", int'(val_out), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_pulse", seen, 0);
        run(512, 9, 0, 1, 0, 0, acc);

        for (int i = 0; i < 150; i++) begin
            v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 1023));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                             : int'($urandom_range(0, 9));
            ev = model(v, s, 1'b1);
            run(v, s, int'($urandom_range(0, 2)), ev, (s >= W) ? 1 : 0,
                (ev == 0) ? 1 : 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
